fadd_sched: RTL and testbench
=============================

FADD_SCHED -- requirements
Module: fadd_sched

Interface
REQ-001 Parameter N, default 32: operand/result width in bits (32 or 64).
REQ-002 Parameter LAT, default 3: fixed adder latency in cycles, fu_valid to fu_ready.
REQ-003 Parameter TAGW, default 4: requester tag width in bits.
REQ-004 Parameter DEPTH, default 4: result buffer entries; DEPTH >= LAT+1 is required.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 reqX_valid, reqX_ready  in/out  1 each, X=0,1  per-requester issue handshake.
REQ-008 reqX_a, reqX_b  in  N each  operands; reqX_frm  in  3  rounding mode; reqX_tag  in  TAGW  requester tag.
REQ-009 fu_valid  out  1; fu_a, fu_b  out  N; fu_frm  out  3: registered issue to the adder.
REQ-010 fu_ready  in  1; fu_out  in  N; fu_flags  in  4: adder result and flags {of,uf,nx,inv}.
REQ-011 res_valid  out  1; res_ready  in  1; res_data  out  N; res_flags  out  4; res_tag  out  TAGW; res_src  out  1: writeback stream.
REQ-012 flush  in  1: discards all accepted, unreturned operations.
REQ-013 err  out  1: sticky protocol-error flag.

Function
REQ-014 Transfer on a request or result port occurs when valid and ready are both high at a rising edge.
REQ-015 Credit rule: occ = buffered results + in-flight ops; no request is accepted while occ == DEPTH.
REQ-016 Arbitration: round-robin with a last-grant pointer. A lone valid requester is granted. If both are valid, the requester not last granted wins. At most one request is accepted per cycle.
REQ-017 reqX_ready is combinational from credit, both valids and the pointer; it is low for the losing requester and during flush.
REQ-018 An accept at edge k drives fu_valid=1 with that request's a/b/frm during cycle k+1. fu_valid=0 in cycles with no accept, and fu_a/fu_b/fu_frm hold their previous values.
REQ-019 A LAT+1 stage tracker shift register carries {valid, kill, src, tag} per issued op. Its output stage lines up with fu_ready, expected in cycle k+1+LAT.
REQ-020 If the tracker output is valid, not killed and fu_ready=1: push {fu_out, fu_flags, tag, src} into the FIFO.
REQ-021 If the tracker output is valid and killed: consume fu_ready silently and push nothing.
REQ-022 Set err=1 if the tracker expects a result and fu_ready=0, or if fu_ready=1 with no tracked op; nothing is pushed in either case.
REQ-023 The FIFO is in-order with DEPTH entries. The res_* signals come from the head register. With an empty FIFO, res_valid rises in cycle k+2+LAT.
REQ-024 res_* holds stable while res_valid=1 and res_ready=0.
REQ-025 A push and a pop in the same cycle leave the count unchanged. The credit rule guarantees no push to a full FIFO; a violation sets err.
REQ-026 Flush at edge f: FIFO emptied, res_valid=0 from cycle f+1, and all tracker valid entries get kill=1. No request is accepted in cycle f; occ counts killed entries until they drain.
REQ-027 A request accepted in the same cycle as flush deasserts is unaffected.
REQ-028 The in-flight counter and FIFO pointers wrap modulo their ranges; the occupancy count is sized to hold DEPTH exactly.

Reset
REQ-029 While rst=1, all of these are 0: reqX_ready, fu_valid, fu_a, fu_b, fu_frm, res_valid, res_data, res_flags, res_tag, res_src and err.
REQ-030 While rst=1, the tracker, FIFO and counters are cleared and the pointer is set so req0 wins the first tie.
REQ-031 Operations in flight at reset are forgotten. A late fu_ready arriving after reset release sets err, and the bench does not drive one.
REQ-032 err clears only on reset.

Verification
REQ-033 Single op: req0 a=0x3F800000, b=0x40000000, tag=5, adder model returns 0x40400000 -> res_valid at cycle k+5 (LAT=3), res_data=0x40400000, res_tag=5, res_src=0.
REQ-034 Contention: req0 and req1 valid every cycle for 8 cycles with res_ready=1 -> grants alternate 0,1,0,1,...; 8 results return in grant order with matching tags.
REQ-035 Backpressure: res_ready=0 with continuous requests -> exactly DEPTH=4 accepts, then reqX_ready=0. res_ready=1 for one cycle -> one pop, one further accept; no result lost or reordered.
REQ-036 Flush: flush while 2 ops in flight and 1 buffered -> res_valid=0 next cycle, none of the 3 results ever appear, err stays 0, and a new op afterwards returns normally.
REQ-037 Protocol error: model withholds fu_ready for one expected op -> err=1 and stays 1 until rst.
REQ-038 Reset mid-operation: rst asserted with 3 ops in flight -> all outputs 0 immediately, and after release the first tie grants req0.

Source files
------------

// File: rtl/fadd_sched.sv
// rtl/fadd_sched.sv - two-requester round-robin issue to a fixed-latency FP adder with in-order result buffer
// Credits cover in-flight and buffered results, so the result FIFO can never overflow.
module fadd_sched #(
  parameter int N     = 32,
  parameter int LAT   = 3,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [N-1:0]    req0_a,
  input  logic [N-1:0]    req0_b,
  input  logic [2:0]      req0_frm,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [N-1:0]    req1_a,
  input  logic [N-1:0]    req1_b,
  input  logic [2:0]      req1_frm,
  input  logic [TAGW-1:0] req1_tag,
  output logic            fu_valid,
  output logic [N-1:0]    fu_a,
  output logic [N-1:0]    fu_b,
  output logic [2:0]      fu_frm,
  input  logic            fu_ready,
  input  logic [N-1:0]    fu_out,
  input  logic [3:0]      fu_flags,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    res_data,
  output logic [3:0]      res_flags,
  output logic [TAGW-1:0] res_tag,
  output logic            res_src,
  input  logic            flush,
  output logic            err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = N + 4 + TAGW + 1;

  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [OW-1:0]   occ;
  logic            last;
  logic            can_take;
  logic            both;
  logic            acc0;
  logic            acc1;
  logic            accept;
  logic [LAT:0]    trk_v;
  logic [LAT:0]    trk_k;
  logic [LAT:0]    trk_s;
  logic [TAGW-1:0] trk_t [LAT+1];
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            full;
  logic            push_ok;
  logic            push;
  logic            pop;
  logic            err_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // last==1 means req1 was granted most recently, so req0 wins the next tie
  assign occ        = OW'(count) + OW'(inflight);
  assign can_take   = !rst && !flush && (occ < OW'(DEPTH));
  assign both       = req0_valid && req1_valid;
  assign req0_ready = can_take && !(both && !last);
  assign req1_ready = can_take && !(both && last);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;

  assign full    = (count == CW'(DEPTH));
  assign pop     = res_valid && res_ready && !flush;
  assign push_ok = trk_v[LAT] && !trk_k[LAT] && fu_ready && !flush;
  assign push    = push_ok && !(full && !pop);
  assign err_set = (trk_v[LAT] && !fu_ready) || (fu_ready && !trk_v[LAT]) ||
                   (push_ok && full && !pop);

  assign res_valid = (count != '0);
  assign {res_data, res_flags, res_tag, res_src} = mem[rd_ptr];

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !trk_v[LAT])
      inflight_nxt = inflight + 1'b1;
    else if (!accept && trk_v[LAT])
      inflight_nxt = inflight - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_valid <= 1'b0;
      fu_a     <= '0;
      fu_b     <= '0;
      fu_frm   <= '0;
      last     <= 1'b1;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      fu_valid <= accept;
      inflight <= inflight_nxt;
      if (accept) begin
        fu_a   <= acc1 ? req1_a : req0_a;
        fu_b   <= acc1 ? req1_b : req0_b;
        fu_frm <= acc1 ? req1_frm : req0_frm;
        last   <= acc1;
      end
      if (err_set)
        err <= 1'b1;
    end
  end

  // Tracker stage LAT lines up with the adder's fu_ready for the op it carries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_v <= '0;
      trk_k <= '0;
      trk_s <= '0;
      for (int i = 0; i <= LAT; i++)
        trk_t[i] <= '0;
    end else begin
      trk_v[0] <= accept;
      trk_k[0] <= 1'b0;
      trk_s[0] <= acc1;
      trk_t[0] <= acc1 ? req1_tag : req0_tag;
      for (int i = 1; i <= LAT; i++) begin
        trk_v[i] <= trk_v[i-1];
        trk_k[i] <= trk_k[i-1] | (flush & trk_v[i-1]);
        trk_s[i] <= trk_s[i-1];
        trk_t[i] <= trk_t[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {fu_out, fu_flags, trk_t[LAT], trk_s[LAT]};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_fadd_sched.sv
// tb/tb_fadd_sched.sv - directed and randomized self-check of fadd_sched against a queue-based model
module tb_fadd_sched;
  localparam int N = 32, LAT = 3, TAGW = 4, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_frm, req1_frm;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic fu_valid, fu_ready;
  logic [N-1:0] fu_a, fu_b, fu_out;
  logic [2:0] fu_frm;
  logic [3:0] fu_flags;
  logic res_valid, res_ready, res_src, flush, err;
  logic [N-1:0] res_data;
  logic [3:0] res_flags;
  logic [TAGW-1:0] res_tag;

  always #5 clk = ~clk;

  fadd_sched #(.N(N), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_frm(req0_frm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_frm(req1_frm), .req1_tag(req1_tag),
    .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_frm(fu_frm),
    .fu_ready(fu_ready), .fu_out(fu_out), .fu_flags(fu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .res_tag(res_tag), .res_src(res_src), .flush(flush), .err(err)
  );

  typedef struct {
    logic [N-1:0]    data;
    logic [3:0]      flags;
    logic [TAGW-1:0] tag;
    logic            src;
  } res_t;

  typedef struct {
    int           due;
    logic [N-1:0] out;
    logic [3:0]   flags;
    bit           drop;
  } fu_t;

  res_t exp_q[$];
  fu_t  fu_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;
  int   cyc = 0;
  bit   expect_err = 0;
  bit   drop_next = 0;

  function automatic logic [N-1:0] fmodel(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] frm);
    if (a == 32'h3F800000 && b == 32'h40000000)
      return 32'h40400000;
    return a + b + N'(frm);
  endfunction

  function automatic logic [3:0] fflags(logic [N-1:0] a, logic [N-1:0] b);
    return a[3:0] ^ b[7:4];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req0_a = $urandom; req0_b = $urandom; req0_frm = 3'($urandom); req0_tag = TAGW'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_frm = 3'($urandom); req1_tag = TAGW'($urandom);
  endtask

  // Adder model: returns each issued op exactly LAT cycles after it was seen on fu_valid
  initial begin
    fu_t e;
    fu_ready = 1'b0;
    fu_out = '0;
    fu_flags = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        fu_q.delete();
        fu_ready = 1'b0;
      end else begin
        if (fu_valid) begin
          e.due = cyc + LAT;
          e.out = fmodel(fu_a, fu_b, fu_frm);
          e.flags = fflags(fu_a, fu_b);
          e.drop = drop_next;
          drop_next = 0;
          fu_q.push_back(e);
        end
        fu_ready = 1'b0;
        if (fu_q.size() > 0 && fu_q[0].due == cyc) begin
          fu_ready = !fu_q[0].drop;
          fu_out = fu_q[0].out;
          fu_flags = fu_q[0].flags;
          void'(fu_q.pop_front());
        end
      end
    end
  end

  // Scoreboard: grant order, credit limit, result order and content, holding under backpressure
  bit   last_g = 1;
  bit   prev_hold = 0;
  res_t prev_res;
  res_t mr;
  res_t got;
  bit   a0, a1;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_g = 1;
      prev_hold = 0;
    end else begin
      if (!expect_err)
        check("err_low", err, 0);
      got.data = res_data; got.flags = res_flags; got.tag = res_tag; got.src = res_src;
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", {got.data, got.flags, got.tag, got.src},
              {prev_res.data, prev_res.flags, prev_res.tag, prev_res.src});
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (flush) begin
        check("flush_rdy0", req0_ready, 0);
        check("flush_rdy1", req1_ready, 0);
        exp_q.delete();
      end else begin
        if (exp_q.size() >= DEPTH)
          check("credit_block", a0 || a1, 0);
        if (res_valid && res_ready) begin
          pop_cnt++;
          check("res_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mr = exp_q.pop_front();
            check("res_data", res_data, mr.data);
            check("res_flags", res_flags, mr.flags);
            check("res_tag", res_tag, mr.tag);
            check("res_src", res_src, mr.src);
          end
        end
        if (a0 || a1) begin
          check("single_grant", a0 && a1, 0);
          if (req0_valid && req1_valid)
            check("rr_winner", a1, !last_g);
          mr.data  = a1 ? fmodel(req1_a, req1_b, req1_frm) : fmodel(req0_a, req0_b, req0_frm);
          mr.flags = a1 ? fflags(req1_a, req1_b) : fflags(req0_a, req0_b);
          mr.tag   = a1 ? req1_tag : req0_tag;
          mr.src   = a1;
          exp_q.push_back(mr);
          last_g = a1;
          acc_cnt++;
        end
      end
      prev_hold = res_valid && !res_ready && !flush;
      prev_res = got;
    end
  end

  initial begin
    int a_s, p_s, n;
    req0_valid = 1; req1_valid = 1; res_ready = 0; flush = 0;
    rand_ops();
    repeat (2) tick();
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_fu_valid", fu_valid, 0);
    check("rst_fu_a", fu_a, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);

    // single op: result visible 4 edges after the accept edge
    req1_valid = 0;
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_frm = 0; req0_tag = 5;
    rst = 0;
    tick();
    req0_valid = 0;
    check("one_fu_valid", fu_valid, 1);
    check("one_fu_a", fu_a, 32'h3F800000);
    check("one_fu_b", fu_b, 32'h40000000);
    tick();
    check("one_fu_idle", fu_valid, 0);
    check("one_fu_hold", fu_a, 32'h3F800000);
    repeat (2) tick();
    check("one_res_early", res_valid, 0);
    tick();
    check("one_res_valid", res_valid, 1);
    check("one_res_data", res_data, 32'h40400000);
    check("one_res_tag", res_tag, 5);
    check("one_res_src", res_src, 0);
    res_ready = 1;
    tick();
    check("one_res_popped", res_valid, 0);

    // contention: both valid until 8 grants
    a_s = acc_cnt; p_s = pop_cnt; n = 0;
    req0_valid = 1; req1_valid = 1;
    while (acc_cnt - a_s < 8 && n < 60) begin
      rand_ops();
      tick();
      n++;
    end
    req0_valid = 0; req1_valid = 0;
    check("contend_accepts", acc_cnt - a_s, 8);
    repeat (12) tick();
    check("contend_returns", pop_cnt - p_s, 8);
    check("contend_drained", exp_q.size(), 0);

    // backpressure: credits stop at DEPTH, one pop frees one accept
    res_ready = 0; a_s = acc_cnt; p_s = pop_cnt;
    req0_valid = 1;
    repeat (12) begin rand_ops(); tick(); end
    #2;
    check("bp_accepts", acc_cnt - a_s, DEPTH);
    check("bp_blocked", req0_ready, 0);
    a_s = acc_cnt;
    res_ready = 1;
    tick();
    res_ready = 0;
    repeat (8) begin rand_ops(); tick(); end
    check("bp_one_pop", pop_cnt - p_s, 1);
    check("bp_one_more", acc_cnt - a_s, 1);
    req0_valid = 0; res_ready = 1;
    repeat (12) tick();
    check("bp_drained", exp_q.size(), 0);
    check("bp_total_pops", pop_cnt - p_s, DEPTH + 1);

    // flush with one buffered result and two in flight
    res_ready = 0;
    rand_ops(); req0_valid = 1; tick();
    req0_valid = 0; repeat (2) tick();
    rand_ops(); req0_valid = 1; tick();
    rand_ops(); tick();
    rand_ops(); flush = 1;
    #2;
    check("fl_buffered", res_valid, 1);
    check("fl_ready_low", req0_ready, 0);
    tick();
    flush = 0; req0_valid = 0;
    check("fl_res_cleared", res_valid, 0);
    res_ready = 1; p_s = pop_cnt;
    repeat (10) tick();
    check("fl_no_results", pop_cnt - p_s, 0);
    check("fl_err", err, 0);
    rand_ops(); req0_valid = 1; tick();
    req0_valid = 0;
    repeat (8) tick();
    check("fl_new_op", pop_cnt - p_s, 1);

    // protocol error: adder withholds one result
    expect_err = 1; drop_next = 1;
    rand_ops(); req1_valid = 1; tick();
    req1_valid = 0;
    repeat (4) tick();
    check("perr_set", err, 1);
    repeat (5) tick();
    check("perr_sticky", err, 1);
    rst = 1;
    #2;
    check("perr_rst_clear", err, 0);
    repeat (2) tick();
    rst = 0; expect_err = 0;
    tick();

    // reset with ops in flight, then the first tie goes to req0
    req0_valid = 1; req1_valid = 1;
    repeat (3) begin rand_ops(); tick(); end
    rst = 1;
    #2;
    check("mid_rst_fu_valid", fu_valid, 0);
    check("mid_rst_fu_a", fu_a, 0);
    check("mid_rst_fu_frm", fu_frm, 0);
    check("mid_rst_rdy0", req0_ready, 0);
    check("mid_rst_rdy1", req1_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_tag", res_tag, 0);
    repeat (2) tick();
    rst = 0;
    #2;
    check("post_rst_rdy0", req0_ready, 1);
    check("post_rst_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (10) tick();
    check("post_rst_drained", exp_q.size(), 0);

    // random traffic with occasional flushes
    repeat (400) begin
      rand_ops();
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(3) != 0);
      flush = ($urandom_range(49) == 0);
      res_ready = !flush && ($urandom_range(2) != 0);
      tick();
    end
    req0_valid = 0; req1_valid = 0; flush = 0; res_ready = 1;
    repeat (15) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
